// File: rtl/hazard3_muldiv_iter.sv
// Iterative RV32M/RV64M multiply/divide unit for the Hazard3 execute stage.
// Retires UNROLL bits per clock. A multiply finishes early once the
// remaining multiplier bits are zero. A divide by zero completes straight
// from the pre-adjust cycle. result_vld is a separate sticky flag.
// Optional feature macro: HAZARD3_MULDIV_CACHE_EN. When it is defined, a
// one-entry quotient/remainder cache lets the second op of a DIV/REM pair
// on the same operands complete in a single cycle.
module hazard3_muldiv_iter #(
  parameter int XLEN    = 32,
  parameter int UNROLL  = 1,
  parameter int W_MULOP = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [W_MULOP-1:0] op,
  input  logic               op_vld,
  output logic               op_rdy,
  input  logic               op_kill,
  input  logic [XLEN-1:0]    op_a,
  input  logic [XLEN-1:0]    op_b,
  output logic [XLEN-1:0]    result_h,
  output logic [XLEN-1:0]    result_l,
  output logic               result_vld
);

  localparam int          N        = XLEN / UNROLL;
  localparam int          CW       = $clog2(N + 1);
  localparam int unsigned UNROLL_U = UNROLL;

  localparam logic [W_MULOP-1:0] OP_MUL    = W_MULOP'(0);
  localparam logic [W_MULOP-1:0] OP_MULH   = W_MULOP'(1);
  localparam logic [W_MULOP-1:0] OP_MULHSU = W_MULOP'(2);
  localparam logic [W_MULOP-1:0] OP_MULHU  = W_MULOP'(3);
  localparam logic [W_MULOP-1:0] OP_DIV    = W_MULOP'(4);
  localparam logic [W_MULOP-1:0] OP_DIVU   = W_MULOP'(5);
  localparam logic [W_MULOP-1:0] OP_REM    = W_MULOP'(6);
  localparam logic [W_MULOP-1:0] OP_REMU   = W_MULOP'(7);

  typedef enum logic [2:0] {
    IDLE,
    PREADJ,
    ITER,
    ALIGN,
    POST_L,
    POST_H
  } state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      ctr, ctr_nxt;
  logic [2*XLEN-1:0]  acc, acc_nxt, acc_step;
  logic [XLEN-1:0]    opnd, opnd_nxt;
  logic [XLEN-1:0]    a_r, b_r;
  logic [W_MULOP-1:0] op_r;
  logic               carry_r, carry_nxt;
  logic               done, accept;

  logic               is_div, div_signed, is_rem, a_signed, b_signed;
  logic               neg_a, neg_b, fix_needed;
  logic [XLEN-1:0]    a_abs, b_abs, rem_mask;
  logic [XLEN:0]      rem_ext, trial, sum;
  int unsigned        rem_bits, align_amt;

  logic               cache_hit;
  logic [2*XLEN-1:0]  cache_acc;

  assign op_rdy   = (state == IDLE);
  assign accept   = op_vld && (op_rdy || op_kill);
  assign result_h = acc[2*XLEN-1:XLEN];
  assign result_l = acc[XLEN-1:0];

  // Operation decode. MUL is treated as signed x signed: the low half is
  // unaffected, and small negative operands still benefit from early-out.
  assign is_div     = (op_r == OP_DIV) || (op_r == OP_DIVU) || (op_r == OP_REM) || (op_r == OP_REMU);
  assign div_signed = (op_r == OP_DIV) || (op_r == OP_REM);
  assign is_rem     = (op_r == OP_REM) || (op_r == OP_REMU);
  assign a_signed   = (op_r == OP_MUL) || (op_r == OP_MULH) || (op_r == OP_MULHSU) || div_signed;
  assign b_signed   = (op_r == OP_MUL) || (op_r == OP_MULH) || div_signed;

  // Operands are held in a_r/b_r for the whole op, so the sign flags are
  // derived from them directly rather than being stored separately.
  assign neg_a      = a_signed && a_r[XLEN-1];
  assign neg_b      = b_signed && b_r[XLEN-1];
  assign a_abs      = neg_a ? -a_r : a_r;
  assign b_abs      = neg_b ? -b_r : b_r;
  assign fix_needed = is_div ? (neg_a || neg_b) : (neg_a ^ neg_b);

  // UNROLL restoring-divide or shift-add-multiply steps.
  // Divide: acc = {remainder, quotient/dividend}, shifting left.
  // Multiply: acc = {product high, product low | unconsumed multiplier}, shifting right.
  always_comb begin
    acc_step = acc;
    rem_ext  = '0;
    trial    = '0;
    sum      = '0;
    for (int unsigned i = 0; i < UNROLL_U; i++) begin
      if (is_div) begin
        rem_ext = acc_step[2*XLEN-1:XLEN-1];
        trial   = rem_ext - {1'b0, opnd};
        if (!trial[XLEN])
          acc_step = {trial[XLEN-1:0], acc_step[XLEN-2:0], 1'b1};
        else
          acc_step = {acc_step[2*XLEN-2:0], 1'b0};
      end else begin
        sum      = {1'b0, acc_step[2*XLEN-1:XLEN]} + (acc_step[0] ? {1'b0, opnd} : '0);
        acc_step = {sum, acc_step[XLEN-1:1]};
      end
    end
  end

  // Next-state and datapath update for the sequencer.
  always_comb begin
    state_nxt = state;
    ctr_nxt   = ctr;
    acc_nxt   = acc;
    opnd_nxt  = opnd;
    carry_nxt = carry_r;
    done      = 1'b0;
    // After this cycle's steps, the low rem_bits of the low half still hold
    // multiplier bits that have not been consumed.
    rem_bits  = (32'(ctr) - 32'd1) * UNROLL_U;
    rem_mask  = '1;
    rem_mask  = ~(rem_mask << rem_bits);
    align_amt = 32'(ctr) * UNROLL_U;
    case (state)
      IDLE: begin
      end
      PREADJ: begin
        ctr_nxt = CW'(N);
        if (is_div) begin
          opnd_nxt = b_abs;
          acc_nxt  = {{XLEN{1'b0}}, a_abs};
          if (b_r == '0) begin
            acc_nxt   = {a_r, {XLEN{1'b1}}};
            state_nxt = IDLE;
            done      = 1'b1;
          end else if (cache_hit) begin
            acc_nxt   = cache_acc;
            state_nxt = IDLE;
            done      = 1'b1;
          end else begin
            state_nxt = ITER;
          end
        end else begin
          opnd_nxt  = a_abs;
          acc_nxt   = {{XLEN{1'b0}}, b_abs};
          state_nxt = (b_abs == '0) ? ALIGN : ITER;
        end
      end
      ITER: begin
        acc_nxt = acc_step;
        ctr_nxt = ctr - 1'b1;
        if (ctr == CW'(1)) begin
          if (fix_needed) begin
            state_nxt = POST_L;
          end else begin
            state_nxt = IDLE;
            done      = 1'b1;
          end
        end else if (!is_div && ((acc_step[XLEN-1:0] & rem_mask) == '0)) begin
          state_nxt = ALIGN;
        end
      end
      ALIGN: begin
        // Skipping the remaining all-zero multiplier bits is just a shift.
        acc_nxt = acc >> align_amt;
        ctr_nxt = '0;
        if (fix_needed) begin
          state_nxt = POST_L;
        end else begin
          state_nxt = IDLE;
          done      = 1'b1;
        end
      end
      POST_L: begin
        if (is_div) begin
          if (neg_a ^ neg_b) acc_nxt[XLEN-1:0] = -acc[XLEN-1:0];
          if (neg_a)         acc_nxt[2*XLEN-1:XLEN] = -acc[2*XLEN-1:XLEN];
          state_nxt = IDLE;
          done      = 1'b1;
        end else begin
          // Two's-complement negate split over two cycles: invert high now,
          // add the low-half carry next cycle.
          acc_nxt   = {~acc[2*XLEN-1:XLEN], -acc[XLEN-1:0]};
          carry_nxt = (acc[XLEN-1:0] == '0);
          state_nxt = POST_H;
        end
      end
      POST_H: begin
        acc_nxt[2*XLEN-1:XLEN] = acc[2*XLEN-1:XLEN] + XLEN'(carry_r);
        state_nxt = IDLE;
        done      = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (accept) begin
      state_nxt = PREADJ;
      done      = 1'b0;
    end else if (op_kill) begin
      state_nxt = IDLE;
      done      = 1'b0;
    end
  end

  // Sequencer state, datapath registers and the sticky result-valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ctr        <= '0;
      acc        <= '0;
      opnd       <= '0;
      carry_r    <= 1'b0;
      op_r       <= '0;
      a_r        <= '0;
      b_r        <= '0;
      result_vld <= 1'b0;
    end else begin
      state   <= state_nxt;
      ctr     <= ctr_nxt;
      acc     <= acc_nxt;
      opnd    <= opnd_nxt;
      carry_r <= carry_nxt;
      if (accept) begin
        op_r <= op;
        a_r  <= op_a;
        b_r  <= op_b;
      end
      if (accept || op_kill)
        result_vld <= 1'b0;
      else if (done)
        result_vld <= 1'b1;
    end
  end

`ifdef HAZARD3_MULDIV_CACHE_EN
  logic            cache_vld;
  logic [XLEN-1:0] cache_a, cache_b, cache_q, cache_r;
  logic            cache_sgn, cache_rem;

  assign cache_hit = cache_vld && (cache_a == a_r) && (cache_b == b_r) &&
                     (cache_sgn == div_signed) && (cache_rem != is_rem);
  assign cache_acc = {cache_r, cache_q};

  // Capture operands and both results of each completed divide; drop on
  // kill or on acceptance of any multiply.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_vld <= 1'b0;
      cache_a   <= '0;
      cache_b   <= '0;
      cache_q   <= '0;
      cache_r   <= '0;
      cache_sgn <= 1'b0;
      cache_rem <= 1'b0;
    end else if (op_kill || (accept && !(op == OP_DIV || op == OP_DIVU || op == OP_REM || op == OP_REMU))) begin
      cache_vld <= 1'b0;
    end else if (done && is_div) begin
      cache_vld <= 1'b1;
      cache_a   <= a_r;
      cache_b   <= b_r;
      cache_q   <= acc_nxt[XLEN-1:0];
      cache_r   <= acc_nxt[2*XLEN-1:XLEN];
      cache_sgn <= div_signed;
      cache_rem <= is_rem;
    end
  end
`else
  assign cache_hit = 1'b0;
  assign cache_acc = '0;
`endif

endmodule

// File: tb/tb_hazard3_muldiv_iter.sv
// Scoreboard bench for hazard3_muldiv_iter (XLEN=32, UNROLL=1).
module tb_hazard3_muldiv_iter;

  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
  localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  op = '0;
  logic        op_vld = 1'b0;
  logic        op_rdy;
  logic        op_kill = 1'b0;
  logic [31:0] op_a = '0, op_b = '0;
  logic [31:0] result_h, result_l;
  logic        result_vld;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct {
    int          id;
    logic [31:0] eh;
    logic [31:0] el;
    bit          chk_h;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];

  hazard3_muldiv_iter #(.XLEN(32), .UNROLL(1), .W_MULOP(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op        (op),
    .op_vld    (op_vld),
    .op_rdy    (op_rdy),
    .op_kill   (op_kill),
    .op_a      (op_a),
    .op_b      (op_b),
    .result_h  (result_h),
    .result_l  (result_l),
    .result_vld(result_vld)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Called just after a negedge; returns just after the negedge following acceptance.
  task automatic issue(input int id, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input bit chk_h, input int lat,
                       input bit kill, input bit push);
    int   n;
    exp_t e;
    n = 0;
    while (!op_rdy && !kill) begin
      @(negedge clk);
      n++;
      if (n > 300) begin
        n_chk++;
        n_fail++;
        $display("FAIL vec%0d op_rdy timeout: got 0 expected 1", id);
        return;
      end
    end
    op = o; op_a = a; op_b = b; op_vld = 1'b1; op_kill = kill;
    if (push) begin
      e.id = id; e.eh = eh; e.el = el; e.chk_h = chk_h; e.lat = lat; e.acc_cyc = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    op_vld = 1'b0; op_kill = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!op_rdy) begin
      @(negedge clk);
      n++;
      if (n > 300) begin
        n_chk++;
        n_fail++;
        $display("FAIL idle timeout: got op_rdy 0 expected 1");
        return;
      end
    end
  endtask

  // Monitor: each rising edge of result_vld retires one scoreboard entry.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (result_vld && !prev) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected result: got h=0x%08h l=0x%08h expected none", result_h, result_l);
        end else begin
          e = sb.pop_front();
          check($sformatf("vec%0d result_l", e.id), result_l, e.el);
          if (e.chk_h) check($sformatf("vec%0d result_h", e.id), result_h, e.eh);
          check($sformatf("vec%0d latency", e.id), 32'(cyc - e.acc_cyc), 32'(e.lat));
        end
      end
      prev = result_vld;
    end
  end

  initial begin
    int n;
    int rem_lat;
`ifdef HAZARD3_MULDIV_CACHE_EN
    rem_lat = 1;
`else
    rem_lat = 33;
`endif
    repeat (3) @(negedge clk);
    check("reset op_rdy", 32'(op_rdy), 32'd1);
    check("reset result_vld", 32'(result_vld), 32'd0);
    check("reset result_h", result_h, 32'h0);
    check("reset result_l", result_l, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    //     id  op      a             b             exp_h         exp_l         chkh lat kill push
    issue(1,  MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1, 33, 0, 1);
    issue(2,  MUL,    32'hFFFFFFFD, 32'h00000007, 32'h0,        32'hFFFFFFEB, 0, 7,  0, 1);
    issue(3,  DIV,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1, 34, 0, 1);
    issue(4,  REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1, 34, 0, 1);
    issue(5,  DIVU,   32'd123,      32'd0,        32'd123,      32'hFFFFFFFF, 1, 1,  0, 1);
    issue(6,  DIV,    32'd100,      32'd7,        32'd2,        32'd14,       1, 33, 0, 1);
    issue(7,  REM,    32'd100,      32'd7,        32'd2,        32'd14,       1, rem_lat, 0, 1);
    issue(8,  MUL,    32'd5,        32'd6,        32'd0,        32'd30,       1, 5,  0, 1);
    issue(9,  REM,    32'd100,      32'd7,        32'd2,        32'd14,       1, 33, 0, 1);
    issue(10, MULH,   32'hFFFFFFFE, 32'hFFFFFFFD, 32'h0,        32'd6,        1, 4,  0, 1);
    issue(11, MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1, 35, 0, 1);
    issue(12, MULHSU, 32'hFFFF0000, 32'h00010000, 32'hFFFFFFFF, 32'h00000000, 1, 21, 0, 1);
    issue(13, DIVU,   32'd7,        32'd9,        32'd7,        32'd0,        1, 33, 0, 1);
    issue(14, DIV,    32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1, 34, 0, 1);

    // Kill mid-iteration with a new op in the same cycle.
    issue(90, MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 0, 0, 0, 0);
    repeat (10) @(negedge clk);
    issue(15, MULHU,  32'd2,        32'd3,        32'd0,        32'd6,        1, 4,  1, 1);
    check("kill_vld op_rdy stays low", 32'(op_rdy), 32'd0);
    wait_idle();

    // Kill with no new op.
    issue(91, DIVU,   32'd1000,     32'd3,        32'h0, 32'h0, 0, 0, 0, 0);
    repeat (5) @(negedge clk);
    op_kill = 1'b1;
    @(negedge clk);
    op_kill = 1'b0;
    check("kill op_rdy", 32'(op_rdy), 32'd1);
    check("kill result_vld", 32'(result_vld), 32'd0);

    issue(17, MUL,    32'd5,        32'd0,        32'd0,        32'd0,        1, 2,  0, 1);
    issue(16, DIV,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1, 1,  0, 1);
    wait_idle();
    repeat (3) @(negedge clk);
    check("held result_vld", 32'(result_vld), 32'd1);
    check("held result_h", result_h, 32'hFFFFFFFB);
    check("held result_l", result_l, 32'hFFFFFFFF);

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard3_muldiv_iter.md
# hazard3_muldiv_iter

Parametrised iterative multiply/divide unit for the Hazard3 execute stage, covering all eight RV32M/RV64M operations at UNROLL bits per clock. It extends the 1-bit-per-clock sequential unit with arbitrary XLEN, multiply early termination, a divide-by-zero short path and a separate sticky result-valid flag. A compile-time option adds a one-entry quotient/remainder cache so a DIV/REM pair on the same operands costs one full iteration.

## Interface
- XLEN, 32: operand width; power of 2, minimum 8.
- UNROLL, 1: bits retired per iteration cycle; power of 2, must divide XLEN.
- W_MULOP, 3: op encoding width; 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- op  in  W_MULOP  operation, sampled on accept.
- op_vld  in  1  request valid.
- op_rdy  out  1  unit idle; accept when op_vld && op_rdy.
- op_kill  in  1  abort current op; op_vld may be high in the same cycle.
- op_a, op_b  in  XLEN  operands (rs1, rs2), sampled on accept.
- result_h  out  XLEN  mulh*/rem* result.
- result_l  out  XLEN  mul/div* result.
- result_vld  out  1  results valid; held until next accept or kill.

## Operation
- States: IDLE, PREADJ, ITER, ALIGN, POST_L, POST_H.
- Accept (op_vld && op_rdy, or op_vld && op_kill): latch op, operands; go PREADJ; result_vld clears.
- PREADJ (always 1 cycle): take |a|, |b| per signedness (a signed: MULH, MULHSU, DIV, REM; b signed: MULH, DIV, REM); record sign flags; ctr = XLEN/UNROLL. DIV*/REM* with b==0 go straight to completion: quotient all-ones, remainder = a unmodified.
- ITER: UNROLL restoring-divide or shift-add-multiply steps per cycle; ctr decrements by 1.
- Multiply early-out: at start of an ITER cycle, if all unconsumed multiplier bits are zero, go ALIGN instead: shift accumulator right by ctr*UNROLL in one cycle, then continue as after last iteration.
- Post-adjust: mul with differing signs: POST_L negates low half, inverts high half; POST_H increments high half only if low negate carried out. Div: quotient negated if sign(a)^sign(b) (b≠0), remainder negated if sign(a). One POST_L cycle covers both div fixes. No fix needed: skip.
- Overflow DIV(MIN, −1): q = MIN, r = 0, arising naturally; no special path.
- MUL returns low half in result_l; MULH* in result_h; DIV* in result_l; REM* in result_h. Both halves valid for every op.
- op_kill without op_vld: return to IDLE next cycle, result_vld low, accumulator contents undefined.

## Timing
- Reset: op_rdy=1, result_vld=0, result_h=result_l=0, state IDLE.
- op_rdy high only in IDLE; result_vld high in IDLE after a completed, unkilled op.
- Latency (accept edge to result_vld high) = 1 + N + A + P cycles: N = XLEN/UNROLL iterations (fewer with early-out), A = 1 if ALIGN used, P = 0/1/2 per post-adjust.
- Unsigned MULHU/DIVU, XLEN=32, UNROLL=1, no early-out: 33 cycles. Divide by zero: 1 cycle.
- Back-to-back: new op may be accepted on the cycle result_vld first rises; results change one cycle later.
- Kill with op_vld same cycle: new op in PREADJ next cycle; op_rdy stays low.

## Configuration
- HAZARD3_MULDIV_CACHE_EN defined: after a completed DIV/DIVU/REM/REMU, store {a, b, signedness} and both quotient and remainder. A subsequent op of the same signedness class and opposite kind (DIV↔REM, DIVU↔REMU) with identical operands completes in 1 cycle (result_vld the cycle after accept). Cache invalidated by reset, kill, or any multiply.
- Not defined: no cache storage; every divide runs the full sequence.

## Test plan
- MULHU 0xFFFFFFFF × 0xFFFFFFFF, XLEN=32, UNROLL=1 -> result_h 0xFFFFFFFE, result_l 0x00000001, result_vld 33 cycles after accept.
- MUL −3 × 7 with op_b=0x00000007 -> early-out after 3 iterations + ALIGN + POST_L/POST_H; result_l 0xFFFFFFEB, total latency 7.
- DIV 0x80000000 / 0xFFFFFFFF -> result_l 0x80000000, result_h 0; REM −7 / 2 -> result_h 0xFFFFFFFF, result_l 0xFFFFFFFD.
- DIVU 123 / 0 -> 1-cycle completion, result_l 0xFFFFFFFF, result_h 123.
- Kill at iteration 10 with op_vld high carrying MULHU 2×3 -> no ready gap, result_h 0, result_l 6 at normal latency; kill without op_vld -> op_rdy high next cycle, result_vld low.
- With HAZARD3_MULDIV_CACHE_EN: DIV 100/7 then REM 100/7 -> second result_h 2 one cycle after accept; insert MUL between -> REM takes full latency.
